clk_div_prog: RTL and testbench

- Runtime-programmable integer clock divider; next generation of the fixed-DIV divider.
- Generates a registered divided clock-enable/clock `clk_out` plus a one-cycle `tick` strobe in the `clk` domain.
- Divisor changes and enable/disable take effect only at period boundaries, so `clk_out` never has a runt pulse.
- Feeds peripheral timebases (UART baud, PWM, sampling strobes).

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_phase.sv | 91 +++++++++
 rtl/clk_div_prog.sv | 114 +++++++++++
 tb/tb_clk_div_prog.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
//   state_e   : divider run state (StIdle / StRun)
//   DIV_MIN   : smallest divisor the hardware accepts
//   clamp_div : raises divisors below DIV_MIN up to DIV_MIN
package clk_div_pkg;

  typedef enum logic {StIdle, StRun} state_e;

  localparam int unsigned DIV_MIN = 2;

  // Callers truncate the result back to their own divisor width.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < DIV_MIN) ? 32'(DIV_MIN) : div;
  endfunction

endpackage

// File: rtl/clk_div_phase.sv
// Period counter and phase generator for clk_div_prog.
// Optional feature macro: ODD_DUTY50_EN (adds a negedge stage for 50% duty on odd divisors).
//   clk_i, rst_ni : clock, async active-low reset
//   run_i         : divider is in the run state
//   en_i          : run request
//   n_i           : active divisor (always >= 2)
//   wrap_o        : current cycle is the last of the period (cnt == N-1)
//   clk_out_o     : divided clock
//   tick_o        : one-cycle strobe at each period start
module clk_div_phase
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] n_i,
  output logic             wrap_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc, high_len;
  logic             phase_q, phase_d;
  logic             tick_q, tick_d;

  always_comb begin
    wrap_o  = (cnt_q == (n_i - WIDTH'(1)));
    cnt_inc = wrap_o ? '0 : (cnt_q + WIDTH'(1));
`ifdef ODD_DUTY50_EN
    // Odd N: posedge phase runs one cycle long; the negedge copy trims half a cycle.
    high_len = (n_i >> 1) + {{(WIDTH-1){1'b0}}, n_i[0]};
`else
    high_len = n_i >> 1;
`endif
  end

  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    tick_d  = 1'b0;
    if (!run_i) begin
      // Start of the first period out of idle.
      if (en_i) begin
        phase_d = 1'b1;
        tick_d  = 1'b1;
      end
    end else if (!(wrap_o && !en_i)) begin
      cnt_d   = cnt_inc;
      phase_d = (cnt_inc < high_len);
      tick_d  = wrap_o && en_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
    end
  end

`ifdef ODD_DUTY50_EN
  logic phase_neg_q;

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_neg_q <= 1'b0;
    end else begin
      phase_neg_q <= phase_q;
    end
  end

  always_comb begin
    clk_out_o = n_i[0] ? (phase_q & phase_neg_q) : phase_q;
  end
`else
  always_comb begin
    clk_out_o = phase_q;
  end
`endif

  assign tick_o = tick_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider.
// Optional feature macro: ODD_DUTY50_EN (50% duty cycle for odd divisors).
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   en         : run request, honoured at period boundaries
//   div_i      : new divisor value
//   div_load   : one-cycle strobe capturing div_i
//   clk_out    : divided clock
//   tick       : one-cycle pulse at each clk_out period start
//   div_active : divisor currently in use
//   upd_pend   : a captured divisor waits for the next period boundary
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIV_DEFAULT = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_i,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             upd_pend
);

  state_e           state_q, state_d;
  logic             run;
  logic             wrap;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             upd_pend_q, upd_pend_d;
  logic [WIDTH-1:0] div_clamped;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (en) state_d = StRun;
      StRun:  if (wrap && !en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    run = (state_q == StRun);
  end

  assign div_clamped = WIDTH'(clamp_div(32'(div_i)));

  always_comb begin
    div_active_d = div_active_q;
    pend_div_d   = pend_div_q;
    upd_pend_d   = upd_pend_q;
    if (!run) begin
      // Idle: a fresh load wins over any value left pending from the last run.
      if (div_load) begin
        div_active_d = div_clamped;
        upd_pend_d   = 1'b0;
      end else if (en && upd_pend_q) begin
        div_active_d = pend_div_q;
        upd_pend_d   = 1'b0;
      end
    end else begin
      if (wrap && upd_pend_q) begin
        div_active_d = pend_div_q;
        upd_pend_d   = 1'b0;
      end
      // A load on the wrap edge is held for the following boundary.
      if (div_load) begin
        pend_div_d = div_clamped;
        upd_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_active_q <= WIDTH'(DIV_DEFAULT);
      pend_div_q   <= '0;
      upd_pend_q   <= 1'b0;
    end else begin
      div_active_q <= div_active_d;
      pend_div_q   <= pend_div_d;
      upd_pend_q   <= upd_pend_d;
    end
  end

  clk_div_phase #(
    .WIDTH(WIDTH)
  ) u_phase (
    .clk_i    (clk),
    .rst_ni   (reset),
    .run_i    (run),
    .en_i     (en),
    .n_i      (div_active_q),
    .wrap_o   (wrap),
    .clk_out_o(clk_out),
    .tick_o   (tick)
  );

  assign div_active = div_active_q;
  assign upd_pend   = upd_pend_q;

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] div_i;
  logic       div_load;
  logic       clk_out;
  logic       tick;
  logic [7:0] div_active;
  logic       upd_pend;

  int n_cmp = 0;
  int n_err = 0;

  clk_div_prog #(
    .WIDTH(8),
    .DIV_DEFAULT(6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .div_i     (div_i),
    .div_load  (div_load),
    .clk_out   (clk_out),
    .tick      (tick),
    .div_active(div_active),
    .upd_pend  (upd_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int c, input int t);
    chk({tag, ".clk_out"}, int'(clk_out), c);
    chk({tag, ".tick"}, int'(tick), t);
  endtask

  initial begin
    reset    = 1'b0;
    en       = 1'b0;
    div_i    = 8'd0;
    div_load = 1'b0;
    step();
    step();
    chk_out("reset", 0, 0);
    chk("reset.div_active", int'(div_active), 6);
    chk("reset.upd_pend", int'(upd_pend), 0);

    // Scenario 1: N=6 free-running, pattern 111000.
    reset = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk_out($sformatf("n6.%0d", i), ((i % 6) < 3) ? 1 : 0, ((i % 6) == 0) ? 1 : 0);
    end
    chk("n6.div_active", int'(div_active), 6);

    // Scenario 2: load 4 at cnt=2; current period still 6 cycles.
    div_i    = 8'd4;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    chk("ld4.upd_pend", int'(upd_pend), 1);
    chk("ld4.div_active", int'(div_active), 6);
    chk_out("ld4.c3", 0, 0);
    step();
    chk_out("ld4.c4", 0, 0);
    step();
    chk_out("ld4.c5", 0, 0);
    chk("ld4.pend_c5", int'(upd_pend), 1);
    step();
    chk_out("ld4.wrap", 1, 1);
    chk("ld4.div_active_wrap", int'(div_active), 4);
    chk("ld4.upd_pend_wrap", int'(upd_pend), 0);
    for (int j = 1; j <= 8; j++) begin
      step();
      chk_out($sformatf("n4.%0d", j), ((j % 4) < 2) ? 1 : 0, ((j % 4) == 0) ? 1 : 0);
    end

    // Scenario 3: div_i=0 then 1, both clamp to 2.
    div_i    = 8'd0;
    div_load = 1'b1;
    step();
    div_i = 8'd1;
    step();
    div_load = 1'b0;
    step();
    chk("clamp.upd_pend", int'(upd_pend), 1);
    chk("clamp.div_active_old", int'(div_active), 4);
    step();
    chk_out("clamp.wrap", 1, 1);
    chk("clamp.div_active", int'(div_active), 2);
    for (int j = 1; j <= 6; j++) begin
      step();
      chk_out($sformatf("n2.%0d", j), ((j % 2) == 0) ? 1 : 0, ((j % 2) == 0) ? 1 : 0);
    end

    // Back to N=6, then drop en at cnt=1.
    div_i    = 8'd6;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    step();
    chk("n6b.div_active", int'(div_active), 6);
    chk_out("n6b.c0", 1, 1);
    step();
    en = 1'b0;
    chk_out("endrop.c1", 1, 0);
    step();
    chk_out("endrop.c2", 1, 0);
    step();
    chk_out("endrop.c3", 0, 0);
    step();
    chk_out("endrop.c4", 0, 0);
    step();
    chk_out("endrop.c5", 0, 0);
    step();
    chk_out("endrop.idle0", 0, 0);
    step();
    chk_out("endrop.idle1", 0, 0);
    step();
    chk_out("endrop.idle2", 0, 0);

    // Idle loads apply directly, without a pending flag.
    div_i    = 8'd0;
    div_load = 1'b1;
    step();
    chk("idle.ld0.div_active", int'(div_active), 2);
    chk("idle.ld0.upd_pend", int'(upd_pend), 0);
    div_i = 8'd5;
    step();
    div_load = 1'b0;
    chk("idle.ld5.div_active", int'(div_active), 5);
    chk_out("idle.ld5", 0, 0);

    // Scenario 5: N=5.
    en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
`ifdef ODD_DUTY50_EN
      chk_out($sformatf("n5.%0d", j), ((j % 5) == 1 || (j % 5) == 2) ? 1 : 0,
              ((j % 5) == 0) ? 1 : 0);
`else
      chk_out($sformatf("n5.%0d", j), ((j % 5) < 2) ? 1 : 0, ((j % 5) == 0) ? 1 : 0);
`endif
    end

    // Load on the wrap edge: held until the following wrap.
    div_i    = 8'd3;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    chk("wrapld.tick", int'(tick), 1);
    chk("wrapld.div_active", int'(div_active), 5);
    chk("wrapld.upd_pend", int'(upd_pend), 1);
    for (int j = 1; j <= 4; j++) step();
    chk("wrapld.pend_c4", int'(upd_pend), 1);
    step();
    chk("wrapld.div_active_next", int'(div_active), 3);
    chk("wrapld.upd_pend_next", int'(upd_pend), 0);
    chk("wrapld.tick_next", int'(tick), 1);

    // Scenario 6: async reset mid-period with an update pending.
    step();
    div_i    = 8'd4;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    chk("rst.pend_before", int'(upd_pend), 1);
    #3;
    reset = 1'b0;
    #1;
    chk_out("rst.async", 0, 0);
    chk("rst.div_active", int'(div_active), 6);
    chk("rst.upd_pend", int'(upd_pend), 0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk_out($sformatf("rst.n6.%0d", i), ((i % 6) < 3) ? 1 : 0, ((i % 6) == 0) ? 1 : 0);
    end
    chk("rst.n6.div_active", int'(div_active), 6);
    chk("rst.n6.upd_pend", int'(upd_pend), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
